// File: rtl/fp_add_normalizer.sv
// fp_add_normalizer: post-add normalise / round / pack stage of the
// single-precision add/sub datapath.
//
// Takes the raw 25-bit significand sum (carry at bit 24, hidden bit at
// bit 23), the provisional biased exponent and the sign. It renormalises
// the sum, applies the carry round-up and packs an IEEE-754 single.
// Only one operation is in flight at a time, over valid/ready handshakes.
//
// Build option: define FP_NORM_LZC_EN to replace the iterative one-bit-
// per-cycle left shift with a single-cycle leading-zero-count shift.
// Results and flags are identical in both builds; only latency differs.
module fp_add_normalizer #(
  parameter int MAX_LSHIFT = 23
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [31:0] in_sig,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_overflow,
  output logic        out_underflow
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    LSHIFT = 3'd2,
    ROUND  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state_r, state_next;
  logic [24:0] sig_r, sig_next;
  logic [8:0]  exp_r, exp_next;   // 9 bits so 255+ and wrap below 1 are visible
  logic        sign_r, sign_next;
  logic        out_valid_r, out_valid_next;
  logic [31:0] result_r, result_next;
  logic        zero_r, zero_next;
  logic        ovf_r, ovf_next;
  logic        unf_r, unf_next;

`ifndef FP_NORM_LZC_EN
  logic [4:0]  cnt_r, cnt_next;   // left shifts performed so far
`endif

  // Adder bits above the carry are not part of the sum.
  logic unused_sig_hi;
  assign unused_sig_hi = ^in_sig[31:25];

  // Round-stage view: absorb a carry left by the CHECK round-up. The bit
  // dropped here is always 0, so no second increment is needed.
  logic [24:0] round_sig;
  logic [8:0]  round_exp;
  assign round_sig = sig_r[24] ? {1'b0, sig_r[24:1]} : sig_r;
  assign round_exp = sig_r[24] ? (exp_r + 9'd1) : exp_r;

  // Carry path: shift right by one, rounding half up on the dropped bit.
  logic [24:0] carry_sig;
  assign carry_sig = {1'b0, sig_r[24:1]} + {24'd0, sig_r[0]};

  // Single-bit left shift used by the iterative build.
  logic [24:0] shl1_sig;
  assign shl1_sig = {sig_r[23:0], 1'b0};

`ifdef FP_NORM_LZC_EN
  // Leading-zero count over the 24-bit significand field (24 when empty).
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) n = 5'(23 - i);
    end
    return n;
  endfunction

  logic [4:0]  lz;
  logic [24:0] shl_lz_sig;
  assign lz         = lzc24(sig_r[23:0]);
  assign shl_lz_sig = sig_r << lz;
`endif

  assign in_ready      = (state_r == IDLE);
  assign out_valid     = out_valid_r;
  assign out_result    = result_r;
  assign out_zero      = zero_r;
  assign out_overflow  = ovf_r;
  assign out_underflow = unf_r;

  // State and datapath registers; reset abandons any operation at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      sig_r       <= '0;
      exp_r       <= '0;
      sign_r      <= 1'b0;
      out_valid_r <= 1'b0;
      result_r    <= '0;
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
      unf_r       <= 1'b0;
`ifndef FP_NORM_LZC_EN
      cnt_r       <= '0;
`endif
    end else begin
      state_r     <= state_next;
      sig_r       <= sig_next;
      exp_r       <= exp_next;
      sign_r      <= sign_next;
      out_valid_r <= out_valid_next;
      result_r    <= result_next;
      zero_r      <= zero_next;
      ovf_r       <= ovf_next;
      unf_r       <= unf_next;
`ifndef FP_NORM_LZC_EN
      cnt_r       <= cnt_next;
`endif
    end
  end

  // Next-state and datapath decisions for each phase of the operation.
  always_comb begin
    state_next     = state_r;
    sig_next       = sig_r;
    exp_next       = exp_r;
    sign_next      = sign_r;
    out_valid_next = out_valid_r;
    result_next    = result_r;
    zero_next      = zero_r;
    ovf_next       = ovf_r;
    unf_next       = unf_r;
`ifndef FP_NORM_LZC_EN
    cnt_next       = cnt_r;
`endif

    unique case (state_r)
      IDLE: begin
        if (in_valid) begin
          sign_next  = in_sign;
          exp_next   = {1'b0, in_exp};
          sig_next   = in_sig[24:0];
`ifndef FP_NORM_LZC_EN
          cnt_next   = '0;
`endif
          state_next = CHECK;
        end
      end

      CHECK: begin
        if (sig_r == '0) begin
          // Exact cancellation always yields +0.
          result_next = 32'h0000_0000;
          zero_next   = 1'b1;
          state_next  = DONE;
        end else if (sig_r[24]) begin
          sig_next   = carry_sig;
          exp_next   = exp_r + 9'd1;
          state_next = ROUND;
        end else if (sig_r[23]) begin
          state_next = ROUND;
        end else begin
          state_next = LSHIFT;
        end
      end

      LSHIFT: begin
`ifdef FP_NORM_LZC_EN
        // The whole normalising shift happens here; flush when the
        // exponent cannot absorb it.
        if (exp_r <= {4'd0, lz}) begin
          result_next = {sign_r, 31'd0};
          unf_next    = 1'b1;
          state_next  = DONE;
        end else begin
          sig_next   = shl_lz_sig;
          exp_next   = exp_r - {4'd0, lz};
          state_next = ROUND;
        end
`else
        // One bit per cycle until the hidden bit arrives or the exponent
        // / iteration budget runs out.
        if ((exp_r <= 9'd1) || (cnt_r == 5'(MAX_LSHIFT))) begin
          result_next = {sign_r, 31'd0};
          unf_next    = 1'b1;
          state_next  = DONE;
        end else begin
          sig_next   = shl1_sig;
          exp_next   = exp_r - 9'd1;
          cnt_next   = cnt_r + 5'd1;
          state_next = shl1_sig[23] ? ROUND : LSHIFT;
        end
`endif
      end

      ROUND: begin
        sig_next = round_sig;
        exp_next = round_exp;
        if (round_exp >= 9'd255) begin
          result_next = {sign_r, 8'hFF, 23'd0};
          ovf_next    = 1'b1;
        end else begin
          result_next = {sign_r, round_exp[7:0], round_sig[22:0]};
        end
        state_next = DONE;
      end

      DONE: begin
        // out_valid rises one cycle after entering DONE, then the result
        // holds until the downstream handshake.
        if (!out_valid_r) begin
          out_valid_next = 1'b1;
        end else if (out_ready) begin
          out_valid_next = 1'b0;
          zero_next      = 1'b0;
          ovf_next       = 1'b0;
          unf_next       = 1'b0;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fp_add_normalizer.sv
// tb_fp_add_normalizer: scoreboard bench for fp_add_normalizer.
// Expected results are queued as each operation is driven and compared
// when the DUT hands the result downstream. Define FP_NORM_LZC_EN for
// both bench and design to check the single-cycle-shift latencies.
module tb_fp_add_normalizer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [31:0] in_sig;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_overflow;
  logic        out_underflow;

  fp_add_normalizer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_sig       (in_sig),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_overflow (out_overflow),
    .out_underflow(out_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;   // {zero, overflow, underflow}
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   hs_cyc = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // Drive one operation, queue its expected outcome, return after accept.
  task automatic send(input logic s, input logic [7:0] e, input logic [31:0] sg,
                      input logic [31:0] res, input logic [2:0] flg,
                      input int lat_iter, input int lat_lzc);
    exp_t x;
    int   n;
    x.res = res;
    x.flg = flg;
`ifdef FP_NORM_LZC_EN
    x.lat = lat_lzc;
`else
    x.lat = lat_iter;
`endif
    sb_q.push_back(x);
    in_sign  = s;
    in_exp   = e;
    in_sig   = sg;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 300);
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      void'(sb_q.pop_back());
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      accept_cyc = cyc;
      in_valid   = 1'b0;
      $display("[TB] sent sign=%0b exp=0x%02h sig=0x%08h expect 0x%08h flags=%03b", s, e, sg, res, flg);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", sb_q.size(), 32'd0);
  endtask

  // Output monitor: latency on out_valid rise, hold checks, compare at handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && !prev_valid) begin
        if (sb_q.size() == 0) check("spurious_valid", 32'd1, 32'd0);
        else check("latency", cyc - accept_cyc, sb_q[0].lat);
      end
      if (out_valid && sb_q.size() != 0) begin
        check("in_ready_busy", {31'd0, in_ready}, 32'd0);
        if (out_ready) begin
          e = sb_q.pop_front();
          check("result", out_result, e.res);
          check("flags", {29'd0, out_zero, out_overflow, out_underflow}, {29'd0, e.flg});
          hs_cyc = cyc + 1;
          $display("[TB] recv result=0x%08h flags=%0b%0b%0b", out_result, out_zero, out_overflow, out_underflow);
        end else begin
          check("hold_result", out_result, sb_q[0].res);
          check("hold_flags", {29'd0, out_zero, out_overflow, out_underflow}, {29'd0, sb_q[0].flg});
        end
      end
    end
    prev_valid = out_valid;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'h00;
    in_sig    = 32'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", out_result, 32'h0);
    check("rst_flags", {29'd0, out_zero, out_overflow, out_underflow}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Normalised, carry, round-up, round-carry paths.
    send(1'b0, 8'h7F, 32'h0080_0000, 32'h3F80_0000, 3'b000, 3, 3);
    send(1'b0, 8'h7F, 32'h0180_0000, 32'h4040_0000, 3'b000, 3, 3);
    send(1'b0, 8'h7F, 32'h0100_0001, 32'h4000_0001, 3'b000, 3, 3);
    send(1'b0, 8'h7F, 32'h01FF_FFFF, 32'h4080_0000, 3'b000, 3, 3);
    // Ignored upper adder bits.
    send(1'b0, 8'h7F, 32'hFE80_0000, 32'h3F80_0000, 3'b000, 3, 3);
    // Left shifts: 23 and 1.
    send(1'b0, 8'h7F, 32'h0000_0001, 32'h3400_0000, 3'b000, 26, 4);
    send(1'b1, 8'h80, 32'h0040_0000, 32'hBF80_0000, 3'b000, 4, 4);
    // Overflow, underflow (after 4 shifts, and on the first shift), zero.
    send(1'b1, 8'hFE, 32'h0100_0000, 32'hFF80_0000, 3'b010, 3, 3);
    send(1'b0, 8'h05, 32'h0000_0001, 32'h0000_0000, 3'b001, 7, 3);
    send(1'b1, 8'h00, 32'h0040_0000, 32'h8000_0000, 3'b001, 3, 3);
    send(1'b1, 8'h01, 32'h0040_0000, 32'h8000_0000, 3'b001, 3, 3);
    send(1'b1, 8'h7F, 32'h0000_0000, 32'h0000_0000, 3'b100, 2, 2);
    drain();

    // Back-pressure: hold out_ready low, second op waits with in_valid high.
    out_ready = 1'b0;
    send(1'b0, 8'h7F, 32'h00C0_0000, 32'h3FC0_0000, 3'b000, 3, 3);
    fork
      send(1'b0, 8'h81, 32'h00A0_0000, 32'h40A0_0000, 3'b000, 3, 3);
      begin
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
          @(posedge clk);
          n++;
        end
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    check("accept_after_hs", accept_cyc, hs_cyc + 1);
    drain();

    // Asynchronous reset in the middle of the left-shift phase.
    send(1'b0, 8'h7F, 32'h0000_0001, 32'h3400_0000, 3'b000, 26, 4);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    void'(sb_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(1'b0, 8'h7F, 32'h0080_0000, 32'h3F80_0000, 3'b000, 3, 3);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
